// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and external bus of the memory arbiter.
// master is the arbiter's view; slave is the pipeline/bus side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_err;
    logic              stallreq_if;
    logic              stallreq_mem;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
        output if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
               bus_err, stallreq_if, stallreq_mem
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
        input  if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
               bus_err, stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between IF and MEM pipeline ports, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; default is fixed MEM-over-IF priority.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    mem_arbiter_if.master p
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic grant_mem, grant_if, done, tmo;
    assign p.stallreq_if = p.if_req & ~p.if_ack;
    assign p.stallreq_mem = p.mem_req & ~p.mem_ack;
    // Arbitrating on stallreq masks a request still held during its own ack cycle.
`ifdef ARB_RR_EN
    logic last_if;
    assign grant_mem = state == IDLE && p.stallreq_mem && (!p.stallreq_if || last_if);
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_if <= 1'b0;
        else if (grant_mem || grant_if) last_if <= grant_if;
`else
    assign grant_mem = state == IDLE && p.stallreq_mem;
`endif
    assign grant_if = state == IDLE && p.stallreq_if && !grant_mem;
    assign done = state != IDLE && p.bus_ack;
    assign tmo = TIMEOUT_CYCLES != 0 && state != IDLE && !p.bus_ack && cnt == LAST;
    always_comb begin
        state_nx = state;
        cnt_nx = '0;
        if (grant_mem) state_nx = BUSY_MEM;
        else if (grant_if) state_nx = BUSY_IF;
        else if (done || tmo) state_nx = IDLE;
        else if (state != IDLE) cnt_nx = cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            p.bus_req <= 1'b0;
            p.bus_we <= 1'b0;
            p.bus_sel <= '0;
            p.bus_addr <= '0;
            p.bus_wdata <= '0;
            p.bus_err <= 1'b0;
            p.if_ack <= 1'b0;
            p.mem_ack <= 1'b0;
            p.if_rdata <= '0;
            p.mem_rdata <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            p.bus_err <= tmo;
            p.if_ack <= state == BUSY_IF && (done || tmo);
            p.mem_ack <= state == BUSY_MEM && (done || tmo);
            if (state == BUSY_IF && (done || tmo)) p.if_rdata <= done ? p.bus_rdata : '0;
            if (state == BUSY_MEM && (done || tmo)) p.mem_rdata <= done && !p.bus_we ? p.bus_rdata : '0;
            if (done || tmo) p.bus_req <= 1'b0;
            if (grant_mem) begin
                p.bus_req <= 1'b1;
                p.bus_we <= p.mem_we;
                p.bus_sel <= p.mem_sel;
                p.bus_addr <= p.mem_addr;
                p.bus_wdata <= p.mem_wdata;
            end else if (grant_if) begin
                p.bus_req <= 1'b1;
                p.bus_we <= 1'b0;
                p.bus_sel <= 4'hF;
                p.bus_addr <= p.if_addr;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch, store, contention, timeout and reset behaviour.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi ();
    mem_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .p(bi));
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        {bi.if_req, bi.if_addr, bi.mem_req, bi.mem_we, bi.mem_sel, bi.mem_addr} = '0;
        {bi.mem_wdata, bi.bus_rdata, bi.bus_ack} = '0;
        rst = 1'b0;
        tick(2);
        checks++;
        if ({bi.bus_req, bi.bus_we, bi.bus_sel, bi.bus_addr, bi.bus_wdata, bi.bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_bus got %0b %h %h", bi.bus_req, bi.bus_addr, bi.bus_wdata);
        end
        checks++;
        if ({bi.if_ack, bi.mem_ack, bi.if_rdata, bi.mem_rdata, bi.stallreq_if, bi.stallreq_mem} !== '0) begin
            errors++;
            $display("FAIL reset_ports got ack %b%b rdata %h %h", bi.if_ack, bi.mem_ack, bi.if_rdata, bi.mem_rdata);
        end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_fetch;
        bi.if_req = 1'b1;
        bi.if_addr = 32'h100;
        tick(1);
        checks++;
        if ({bi.bus_req, bi.bus_we, bi.bus_sel, bi.bus_addr, bi.stallreq_if} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b1}) begin
            errors++;
            $display("FAIL fetch_bus got req %b we %b sel %h addr %h stall %b exp 1 0 f 00000100 1",
                     bi.bus_req, bi.bus_we, bi.bus_sel, bi.bus_addr, bi.stallreq_if);
        end
        tick(1);
        checks++;
        if ({bi.bus_req, bi.if_ack} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_wait got req %b ack %b exp 1 0", bi.bus_req, bi.if_ack);
        end
        bi.bus_ack = 1'b1;
        bi.bus_rdata = 32'h3C010101;
        tick(1);
        checks++;
        if ({bi.if_ack, bi.mem_ack, bi.if_rdata, bi.stallreq_if, bi.bus_req} !== {2'b10, 32'h3C010101, 2'b00}) begin
            errors++;
            $display("FAIL fetch_ack got ack %b rdata %h stall %b req %b exp 1 3c010101 0 0",
                     bi.if_ack, bi.if_rdata, bi.stallreq_if, bi.bus_req);
        end
        bi.bus_ack = 1'b0;
        tick(1);
        checks++;
        if ({bi.if_ack, bi.bus_req} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after got ack %b req %b exp 0 0", bi.if_ack, bi.bus_req);
        end
        bi.if_req = 1'b0;
        tick(1);
    endtask

    task automatic test_store;
        bi.mem_req = 1'b1;
        bi.mem_we = 1'b1;
        bi.mem_sel = 4'b0011;
        bi.mem_addr = 32'h2004;
        bi.mem_wdata = 32'hDEADBEEF;
        bi.bus_ack = 1'b1;
        bi.bus_rdata = 32'h12345678;
        tick(1);
        checks++;
        if ({bi.bus_req, bi.bus_we, bi.bus_sel, bi.bus_addr, bi.bus_wdata, bi.mem_ack} !==
            {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL store_bus got req %b we %b sel %h addr %h wdata %h ack %b",
                     bi.bus_req, bi.bus_we, bi.bus_sel, bi.bus_addr, bi.bus_wdata, bi.mem_ack);
        end
        tick(1);
        checks++;
        if ({bi.mem_ack, bi.if_ack, bi.mem_rdata, bi.bus_req, bi.stallreq_mem} !== {2'b10, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL store_ack got ack %b rdata %h req %b stall %b exp 1 00000000 0 0",
                     bi.mem_ack, bi.mem_rdata, bi.bus_req, bi.stallreq_mem);
        end
        bi.bus_ack = 1'b0;
        tick(1);
        checks++;
        if ({bi.mem_ack, bi.bus_req} !== 2'b00) begin
            errors++;
            $display("FAIL store_after got ack %b req %b exp 0 0", bi.mem_ack, bi.bus_req);
        end
        bi.mem_req = 1'b0;
        tick(1);
    endtask

    task automatic test_contention;
        logic [31:0] a1, a2;
        logic [1:0] k1, k2;
        a1 = RR ? 32'h200 : 32'h3000;
        a2 = RR ? 32'h3000 : 32'h200;
        k1 = RR ? 2'b10 : 2'b01;
        k2 = ~k1;
        bi.if_req = 1'b1;
        bi.if_addr = 32'h200;
        bi.mem_req = 1'b1;
        bi.mem_we = 1'b0;
        bi.mem_sel = 4'hF;
        bi.mem_addr = 32'h3000;
        tick(1);
        checks++;
        if ({bi.bus_req, bi.bus_addr, bi.stallreq_if, bi.stallreq_mem} !== {1'b1, a1, 2'b11}) begin
            errors++;
            $display("FAIL cont_first got req %b addr %h stall %b%b exp addr %h",
                     bi.bus_req, bi.bus_addr, bi.stallreq_if, bi.stallreq_mem, a1);
        end
        bi.bus_ack = 1'b1;
        bi.bus_rdata = 32'hAAAA5555;
        tick(1);
        checks++;
        if ({bi.if_ack, bi.mem_ack, bi.bus_req} !== {k1, 1'b0} ||
            (RR ? bi.if_rdata : bi.mem_rdata) !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL cont_ack1 got ack %b%b rdata %h %h exp ack %b rdata aaaa5555",
                     bi.if_ack, bi.mem_ack, bi.if_rdata, bi.mem_rdata, k1);
        end
        bi.bus_ack = 1'b0;
        tick(1);
        checks++;
        if ({bi.bus_req, bi.bus_addr, bi.if_ack, bi.mem_ack} !== {1'b1, a2, 2'b00}) begin
            errors++;
            $display("FAIL cont_second got req %b addr %h ack %b%b exp 1 %h 00",
                     bi.bus_req, bi.bus_addr, bi.if_ack, bi.mem_ack, a2);
        end
        if (RR) bi.if_req = 1'b0;
        else bi.mem_req = 1'b0;
        bi.bus_ack = 1'b1;
        bi.bus_rdata = 32'h11112222;
        tick(1);
        checks++;
        if ({bi.if_ack, bi.mem_ack, bi.bus_req} !== {k2, 1'b0} ||
            (RR ? bi.mem_rdata : bi.if_rdata) !== 32'h11112222) begin
            errors++;
            $display("FAIL cont_ack2 got ack %b%b rdata %h %h exp ack %b rdata 11112222",
                     bi.if_ack, bi.mem_ack, bi.if_rdata, bi.mem_rdata, k2);
        end
        bi.bus_ack = 1'b0;
        tick(1);
        checks++;
        if ({bi.bus_req, bi.if_ack, bi.mem_ack} !== 3'b000) begin
            errors++;
            $display("FAIL cont_after got req %b ack %b%b exp 0 00", bi.bus_req, bi.if_ack, bi.mem_ack);
        end
        bi.if_req = 1'b0;
        bi.mem_req = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout;
        bi.if_req = 1'b1;
        bi.if_addr = 32'h400;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checks++;
            if ({bi.bus_req, bi.bus_err, bi.if_ack} !== 3'b100) begin
                errors++;
                $display("FAIL tmo_busy cycle %0d got req %b err %b ack %b exp 1 0 0", i, bi.bus_req, bi.bus_err, bi.if_ack);
            end
        end
        tick(1);
        checks++;
        if ({bi.bus_req, bi.bus_err, bi.if_ack, bi.mem_ack, bi.if_rdata} !== {4'b0110, 32'h0}) begin
            errors++;
            $display("FAIL tmo_abort got req %b err %b ack %b%b rdata %h exp 0 1 10 00000000",
                     bi.bus_req, bi.bus_err, bi.if_ack, bi.mem_ack, bi.if_rdata);
        end
        tick(1);
        checks++;
        if ({bi.bus_req, bi.bus_err, bi.if_ack} !== 3'b000) begin
            errors++;
            $display("FAIL tmo_after got req %b err %b ack %b exp 0 0 0", bi.bus_req, bi.bus_err, bi.if_ack);
        end
        bi.if_req = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout_boundary;
        bi.mem_req = 1'b1;
        bi.mem_we = 1'b0;
        bi.mem_sel = 4'hF;
        bi.mem_addr = 32'h500;
        tick(4);
        checks++;
        if ({bi.bus_req, bi.bus_addr, bi.bus_err} !== {1'b1, 32'h500, 1'b0}) begin
            errors++;
            $display("FAIL tmob_busy got req %b addr %h err %b exp 1 00000500 0", bi.bus_req, bi.bus_addr, bi.bus_err);
        end
        bi.bus_ack = 1'b1;
        bi.bus_rdata = 32'hCAFEF00D;
        tick(1);
        checks++;
        if ({bi.mem_ack, bi.bus_err, bi.bus_req, bi.mem_rdata} !== {3'b100, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL tmob_ack got ack %b err %b req %b rdata %h exp 1 0 0 cafef00d",
                     bi.mem_ack, bi.bus_err, bi.bus_req, bi.mem_rdata);
        end
        bi.bus_ack = 1'b0;
        tick(1);
        bi.mem_req = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid;
        bi.mem_req = 1'b1;
        bi.mem_we = 1'b1;
        bi.mem_sel = 4'hF;
        bi.mem_addr = 32'h600;
        bi.mem_wdata = 32'h55AA55AA;
        tick(2);
        checks++;
        if (bi.bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got req %b exp 1", bi.bus_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bi.bus_req, bi.bus_we, bi.bus_addr, bi.bus_wdata, bi.mem_ack} !== '0) begin
            errors++;
            $display("FAIL rstmid_async got req %b we %b addr %h wdata %h ack %b exp all 0",
                     bi.bus_req, bi.bus_we, bi.bus_addr, bi.bus_wdata, bi.mem_ack);
        end
        bi.mem_req = 1'b0;
        bi.bus_ack = 1'b1;
        tick(1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if ({bi.bus_req, bi.mem_ack, bi.if_ack, bi.bus_err} !== 4'b0000) begin
                errors++;
                $display("FAIL rstmid_idle cycle %0d got req %b ack %b%b err %b exp 0 00 0",
                         i, bi.bus_req, bi.mem_ack, bi.if_ack, bi.bus_err);
            end
        end
        bi.bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
